// File: rtl/serial_add_pkg.sv
// Shared constants, state encoding and handshake bundle for the nibble-serial adder.
package serial_add_pkg;
  localparam int NIB_W = 4;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE = S_IDLE,
    ST_RUN  = S_RUN,
    ST_DONE = S_DONE
  } state_e;

  typedef struct packed {
    logic in_ready;
    logic out_valid;
    logic busy;
  } hs_t;

  // Handshake outputs are a pure decode of the registered state.
  function automatic hs_t decode_hs(input state_e s);
    hs_t h;
    h.in_ready  = (s == ST_IDLE);
    h.out_valid = (s == ST_DONE);
    h.busy      = (s != ST_IDLE);
    return h;
  endfunction
endpackage

// File: rtl/cla.sv
// 4-bit carry-lookahead slice: all carries formed directly from generate/propagate terms.
module cla (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] sum,
  output logic       cout
);
  logic [3:0] g;
  logic [3:0] p;
  logic [4:0] c;

  assign g = a & b;
  assign p = a ^ b;

  assign c[0] = cin;
  assign c[1] = g[0] | (p[0] & cin);
  assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
  assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);
  assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
              | (p[3] & p[2] & p[1] & p[0] & cin);

  assign sum  = p ^ c[3:0];
  assign cout = c[4];
endmodule

// File: rtl/serial_cla_adder.sv
// WIDTH-bit adder that pushes one nibble per cycle through a single cla slice,
// carrying between nibbles through a register.
module serial_cla_adder
  import serial_add_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             sys_clk,
  input  logic             sys_rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             busy
);
  localparam int NIBBLES = WIDTH / NIB_W;
  localparam int CW      = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(NIBBLES - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] opa_q, opa_d;
  logic [WIDTH-1:0] opb_q, opb_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  logic [NIB_W-1:0] nib_sum;
  logic             nib_cout;
  hs_t              hs;

  cla u_cla (
    .a    (opa_q[NIB_W-1:0]),
    .b    (opb_q[NIB_W-1:0]),
    .cin  (carry_q),
    .sum  (nib_sum),
    .cout (nib_cout)
  );

  always_comb begin
    state_d = state_q;
    opa_d   = opa_q;
    opb_d   = opb_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          opa_d   = a;
          opb_d   = b;
          carry_d = cin;
          cnt_d   = '0;
          sum_d   = '0;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        // Low nibble first; after NIBBLES shifts the sum sits right-aligned.
        sum_d   = {nib_sum, sum_q[WIDTH-1:NIB_W]};
        carry_d = nib_cout;
        opa_d   = opa_q >> NIB_W;
        opb_d   = opb_q >> NIB_W;
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == LAST) begin
          cout_d  = nib_cout;
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q <= ST_IDLE;
      opa_q   <= '0;
      opb_q   <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      cnt_q   <= cnt_d;
    end
  end

  assign hs        = decode_hs(state_q);
  assign in_ready  = hs.in_ready;
  assign out_valid = hs.out_valid;
  assign busy      = hs.busy;
  assign sum       = sum_q;
  assign cout      = cout_q;
endmodule

// File: tb/tb_serial_cla_adder.sv
// Bench for serial_cla_adder at WIDTH=32 and WIDTH=8 against plain a+b+cin arithmetic.
module tb_serial_cla_adder;
  logic sys_clk = 1'b0;
  logic sys_rst_n = 1'b0;
  always #5 sys_clk = ~sys_clk;

  int tests = 0;
  int fails = 0;

  logic        in_valid32 = 0, out_ready32 = 0, cin32 = 0;
  logic [31:0] a32 = '0, b32 = '0;
  logic        in_ready32, out_valid32, cout32, busy32;
  logic [31:0] sum32;

  logic        in_valid8 = 0, out_ready8 = 0, cin8 = 0;
  logic [7:0]  a8 = '0, b8 = '0;
  logic        in_ready8, out_valid8, cout8, busy8;
  logic [7:0]  sum8;

  serial_cla_adder #(.WIDTH(32)) dut32 (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n),
    .in_valid(in_valid32), .in_ready(in_ready32), .a(a32), .b(b32), .cin(cin32),
    .out_valid(out_valid32), .out_ready(out_ready32), .sum(sum32), .cout(cout32), .busy(busy32)
  );

  serial_cla_adder #(.WIDTH(8)) dut8 (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n),
    .in_valid(in_valid8), .in_ready(in_ready8), .a(a8), .b(b8), .cin(cin8),
    .out_valid(out_valid8), .out_ready(out_ready8), .sum(sum8), .cout(cout8), .busy(busy8)
  );

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  // One full 32-bit transaction: accept, latency, held result under stall, release.
  task automatic run_op32(input logic [31:0] ta, input logic [31:0] tb_, input logic tc,
                          input int stall, input string nm);
    logic [32:0] exp;
    int cyc;
    exp = {1'b0, ta} + {1'b0, tb_} + 33'(tc);
    cyc = 0;
    while (!in_ready32 && cyc < 100) begin tick(); cyc++; end
    a32 = ta; b32 = tb_; cin32 = tc; in_valid32 = 1;
    tick();
    in_valid32 = 0;
    cyc = 0;
    while (!out_valid32 && cyc < 100) begin tick(); cyc++; end
    tests++;
    if (cyc !== 8) begin
      fails++; $display("FAIL %s latency: got %0d cycles, expected 8", nm, cyc);
    end
    for (int s = 0; s <= stall; s++) begin
      tests++;
      if (out_valid32 !== 1'b1 || sum32 !== exp[31:0] || cout32 !== exp[32] || in_ready32 !== 1'b0) begin
        fails++;
        $display("FAIL %s result[%0d]: ov=%b rdy=%b sum=%h cout=%b, expected ov=1 rdy=0 sum=%h cout=%b",
                 nm, s, out_valid32, in_ready32, sum32, cout32, exp[31:0], exp[32]);
      end
      if (s < stall) tick();
    end
    out_ready32 = 1;
    tick();
    out_ready32 = 0;
    tests++;
    if (out_valid32 !== 1'b0 || in_ready32 !== 1'b1 || busy32 !== 1'b0 || sum32 !== exp[31:0]) begin
      fails++;
      $display("FAIL %s release: ov=%b rdy=%b busy=%b sum=%h, expected ov=0 rdy=1 busy=0 sum=%h",
               nm, out_valid32, in_ready32, busy32, sum32, exp[31:0]);
    end
  endtask

  task automatic run_op8(input logic [7:0] ta, input logic [7:0] tb_, input logic tc,
                         input int stall, input string nm);
    logic [8:0] exp;
    int cyc;
    exp = {1'b0, ta} + {1'b0, tb_} + 9'(tc);
    cyc = 0;
    while (!in_ready8 && cyc < 100) begin tick(); cyc++; end
    a8 = ta; b8 = tb_; cin8 = tc; in_valid8 = 1;
    tick();
    in_valid8 = 0;
    cyc = 0;
    while (!out_valid8 && cyc < 100) begin tick(); cyc++; end
    tests++;
    if (cyc !== 2) begin
      fails++; $display("FAIL %s latency: got %0d cycles, expected 2", nm, cyc);
    end
    for (int s = 0; s <= stall; s++) begin
      tests++;
      if (out_valid8 !== 1'b1 || sum8 !== exp[7:0] || cout8 !== exp[8]) begin
        fails++;
        $display("FAIL %s result[%0d]: ov=%b sum=%h cout=%b, expected ov=1 sum=%h cout=%b",
                 nm, s, out_valid8, sum8, cout8, exp[7:0], exp[8]);
      end
      if (s < stall) tick();
    end
    out_ready8 = 1;
    tick();
    out_ready8 = 0;
    tests++;
    if (out_valid8 !== 1'b0 || in_ready8 !== 1'b1) begin
      fails++; $display("FAIL %s release: ov=%b rdy=%b, expected ov=0 rdy=1", nm, out_valid8, in_ready8);
    end
  endtask

  task automatic test_reset();
    sys_rst_n = 0;
    repeat (3) tick();
    tests++;
    if (in_ready32 !== 1 || out_valid32 !== 0 || busy32 !== 0 || sum32 !== 32'h0 || cout32 !== 0) begin
      fails++;
      $display("FAIL reset32: rdy=%b ov=%b busy=%b sum=%h cout=%b, expected 1 0 0 00000000 0",
               in_ready32, out_valid32, busy32, sum32, cout32);
    end
    tests++;
    if (in_ready8 !== 1 || out_valid8 !== 0 || busy8 !== 0 || sum8 !== 8'h0 || cout8 !== 0) begin
      fails++;
      $display("FAIL reset8: rdy=%b ov=%b busy=%b sum=%h cout=%b, expected 1 0 0 00 0",
               in_ready8, out_valid8, busy8, sum8, cout8);
    end
    @(negedge sys_clk);
    sys_rst_n = 1;
    tick();
  endtask

  task automatic test_directed();
    run_op32(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 0, "ripple");
    run_op32(32'h1234_5678, 32'h9ABC_DEF0, 1'b0, 1, "mixed");
    run_op32(32'h0000_0000, 32'h0000_0000, 1'b1, 0, "cin_only");
    run_op32(32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 2, "cin_wrap");
    run_op32(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 0, "all_ones");
  endtask

  task automatic test_backpressure();
    logic [31:0] pa, pb;
    logic [32:0] exp;
    int cyc;
    pa = 32'hDEAD_BEEF; pb = 32'h0123_4567;
    exp = {1'b0, pa} + {1'b0, pb};
    a32 = pa; b32 = pb; cin32 = 0; in_valid32 = 1;
    tick();
    a32 = 32'h5555_5555; b32 = 32'hAAAA_AAAA; cin32 = 1;
    tick();
    tests++;
    if (in_ready32 !== 0 || busy32 !== 1) begin
      fails++; $display("FAIL bp_run: rdy=%b busy=%b, expected rdy=0 busy=1", in_ready32, busy32);
    end
    in_valid32 = 0;
    cyc = 0;
    while (!out_valid32 && cyc < 100) begin tick(); cyc++; end
    a32 = 32'h7777_0000; b32 = 32'h0000_9999; in_valid32 = 1;
    for (int s = 0; s < 5; s++) begin
      tests++;
      if (out_valid32 !== 1 || in_ready32 !== 0 || sum32 !== exp[31:0] || cout32 !== exp[32]) begin
        fails++;
        $display("FAIL bp_hold[%0d]: ov=%b rdy=%b sum=%h cout=%b, expected ov=1 rdy=0 sum=%h cout=%b",
                 s, out_valid32, in_ready32, sum32, cout32, exp[31:0], exp[32]);
      end
      tick();
    end
    in_valid32 = 0;
    out_ready32 = 1;
    tick();
    out_ready32 = 0;
    tests++;
    if (in_ready32 !== 1 || out_valid32 !== 0 || sum32 !== exp[31:0]) begin
      fails++;
      $display("FAIL bp_release: rdy=%b ov=%b sum=%h, expected rdy=1 ov=0 sum=%h",
               in_ready32, out_valid32, sum32, exp[31:0]);
    end
    run_op32(32'h8000_0001, 32'h7FFF_FFFF, 1'b0, 0, "bp_next");
  endtask

  task automatic test_reset_mid_run();
    a32 = 32'h1111_1111; b32 = 32'h2222_2222; cin32 = 1; in_valid32 = 1;
    tick();
    in_valid32 = 0;
    repeat (3) tick();
    #2;
    sys_rst_n = 0;
    #1;
    tests++;
    if (in_ready32 !== 1 || out_valid32 !== 0 || busy32 !== 0 || sum32 !== 32'h0 || cout32 !== 0) begin
      fails++;
      $display("FAIL mid_reset: rdy=%b ov=%b busy=%b sum=%h cout=%b, expected 1 0 0 00000000 0",
               in_ready32, out_valid32, busy32, sum32, cout32);
    end
    @(negedge sys_clk);
    sys_rst_n = 1;
    repeat (10) begin
      tick();
      tests++;
      if (out_valid32 !== 0 || in_ready32 !== 1) begin
        fails++; $display("FAIL mid_reset_idle: ov=%b rdy=%b, expected ov=0 rdy=1", out_valid32, in_ready32);
      end
    end
    run_op32(32'h0000_000F, 32'h0000_0001, 1'b0, 0, "after_reset");
  endtask

  task automatic test_random();
    for (int i = 0; i < 1000; i++)
      run_op8(8'($urandom), 8'($urandom), 1'($urandom), int'($urandom_range(0, 3)), "rand8");
    for (int i = 0; i < 1000; i++)
      run_op32($urandom, $urandom, 1'($urandom), int'($urandom_range(0, 3)), "rand32");
  endtask

  initial begin
    test_reset();
    test_directed();
    test_backpressure();
    test_reset_mid_run();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule
